// File: rtl/shift_pkg.sv
// Shared definitions for the serial LED shift-register link (transmitter and receiver top).
package shift_pkg;

  // Transmitter control states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  // Default link geometry, shared with the receiver top.
  localparam int SHIFT_WIDTH_DEFAULT = 8;
  localparam int HALF_DEFAULT        = 4;

endpackage

// File: rtl/shift_tx8b_bit_tick_gen.sv
// Bit-period timing for shift_tx8b: half counter, sclk level and end-of-bit strobe.
// A bit period is 2*HALF clk cycles; sclk is high for the first HALF of them.
module bit_tick_gen #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,    // word accepted: restart timing at the first high phase
  input  logic run,      // transmitter is shifting
  input  logic last,     // current bit is the final bit of the frame
  output logic sclk,
  output logic bit_end
);

  localparam int CW = $clog2(2 * HALF);
  localparam logic [CW-1:0] HC_LAST = CW'(2 * HALF - 1);
  localparam logic [CW-1:0] HALF_V  = CW'(HALF);

  logic [CW-1:0] hc_r;
  logic [CW-1:0] hc_inc_s;
  logic          sclk_r;

  assign hc_inc_s = hc_r + {{(CW-1){1'b0}}, 1'b1};
  assign bit_end  = run & (hc_r == HC_LAST);
  assign sclk     = sclk_r;

  // Half counter and registered sclk; sclk is computed for the cycle the counter moves into.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc_r   <= {CW{1'b0}};
      sclk_r <= 1'b0;
    end else if (clear) begin
      hc_r   <= {CW{1'b0}};
      sclk_r <= 1'b1;
    end else if (run) begin
      if (hc_r == HC_LAST) begin
        hc_r   <= {CW{1'b0}};
        // next bit opens with a high phase unless the frame is finishing
        sclk_r <= ~last;
      end else begin
        hc_r   <= hc_inc_s;
        sclk_r <= (hc_inc_s < HALF_V);
      end
    end else begin
      hc_r   <= {CW{1'b0}};
      sclk_r <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_tx8b.sv
// Parallel-in, serial-out transmitter for the serial LED shift register.
// Accepts a word on load && ready, shifts it out MSB first with a generated sclk,
// and mirrors the live shift register on led_out.
module shift_tx8b
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH_DEFAULT,
  parameter int HALF  = HALF_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sclk,
  output logic             done,
  output logic [WIDTH-1:0] led_out
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  tx_state_t        state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [BW-1:0]    bitcnt_r;
  logic             ready_r;
  logic             done_r;

  logic accept_s;
  logic run_s;
  logic last_bit_s;
  logic bit_end_s;
  logic sclk_s;

  assign accept_s   = load & ready_r;
  assign run_s      = (state_r == SHIFT);
  assign last_bit_s = (bitcnt_r == BIT_LAST);

  bit_tick_gen #(
    .HALF (HALF)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept_s),
    .run     (run_s),
    .last    (last_bit_s),
    .sclk    (sclk_s),
    .bit_end (bit_end_s)
  );

  // The shift register is all zeros whenever the block is idle (reset or fully
  // shifted out), so its MSB doubles as the serial output in both states.
  assign sout    = shreg_r[WIDTH-1];
  assign sclk    = sclk_s;
  assign ready   = ready_r;
  assign done    = done_r;
  assign led_out = shreg_r;

  // Control FSM with shift register, bit counter and registered ready/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      shreg_r  <= {WIDTH{1'b0}};
      bitcnt_r <= {BW{1'b0}};
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (load) begin
            shreg_r  <= din;
            bitcnt_r <= {BW{1'b0}};
            ready_r  <= 1'b0;
            state_r  <= SHIFT;
          end else begin
            ready_r  <= 1'b1;
            state_r  <= IDLE;
          end
        end
        SHIFT: begin
          if (bit_end_s) begin
            shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
            if (last_bit_s) begin
              // counter is cleared rather than allowed to wrap
              bitcnt_r <= {BW{1'b0}};
              ready_r  <= 1'b1;
              done_r   <= 1'b1;
              state_r  <= IDLE;
            end else begin
              bitcnt_r <= bitcnt_r + {{(BW-1){1'b0}}, 1'b1};
              done_r   <= 1'b0;
            end
          end else begin
            done_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          shreg_r  <= {WIDTH{1'b0}};
          bitcnt_r <= {BW{1'b0}};
          ready_r  <= 1'b1;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_tx8b.sv
// Self-checking bench for shift_tx8b (WIDTH=8, HALF=2): directed scenarios then random
// load/reset traffic, compared every cycle against a frame-timing reference model.
module tb_shift_tx8b;

  localparam int W = 8;
  localparam int H = 2;
  localparam int FRAME = 2 * H * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] din;
  logic         ready;
  logic         sout;
  logic         sclk;
  logic         done;
  logic [W-1:0] led_out;

  int vectors = 0;
  int miscompares = 0;

  // reference model: frame timing derived from the accept cycle
  bit           m_busy = 1'b0;
  int           m_t = 0;
  logic [W-1:0] m_word = '0;
  bit           m_done = 1'b0;

  // model receiver: captures sout on each sclk falling edge
  logic [W-1:0] rx = '0;
  int           falls = 0;
  logic         prev_sclk = 1'b0;

  shift_tx8b #(.WIDTH(W), .HALF(H)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .load    (load),
    .ready   (ready),
    .sout    (sout),
    .sclk    (sclk),
    .done    (done),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check the following cycle.
  task automatic apply(input bit r, input bit l, input logic [W-1:0] d);
    int           idx;
    logic         e_sclk, e_sout, e_ready, e_done;
    logic [W-1:0] e_led;
    rst = r; load = l; din = d;
    @(posedge clk);
    #1;
    if (r) begin
      m_busy = 1'b0; m_done = 1'b0;
    end else if (!m_busy && l) begin
      m_busy = 1'b1; m_t = 1; m_word = d; m_done = 1'b0; falls = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t > FRAME) begin m_busy = 1'b0; m_done = 1'b1; end
      else m_done = 1'b0;
    end else begin
      m_done = 1'b0;
    end

    if (prev_sclk === 1'b1 && sclk === 1'b0) begin
      rx = {rx[W-2:0], sout};
      falls++;
    end
    prev_sclk = sclk;

    if (m_busy) begin
      idx     = (m_t - 1) / (2 * H);
      e_sclk  = (((m_t - 1) % (2 * H)) < H);
      e_sout  = m_word[W-1-idx];
      e_led   = W'(m_word << idx);
      e_ready = 1'b0;
      e_done  = 1'b0;
    end else begin
      e_sclk = 1'b0; e_sout = 1'b0; e_led = '0; e_ready = 1'b1; e_done = m_done;
    end
    chk("ready",   {31'd0, ready}, {31'd0, e_ready});
    chk("sout",    {31'd0, sout},  {31'd0, e_sout});
    chk("sclk",    {31'd0, sclk},  {31'd0, e_sclk});
    chk("done",    {31'd0, done},  {31'd0, e_done});
    chk("led_out", {24'd0, led_out}, {24'd0, e_led});
    if (m_done) begin
      chk("rx_word", {24'd0, rx}, {24'd0, m_word});
      chk("sclk_falls", falls, W);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) apply(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; din = 8'h00;
    // reset values
    repeat (3) apply(1'b1, 1'b0, 8'h00);
    idle(2);
    // single frame
    apply(1'b0, 1'b1, 8'hA5);
    idle(35);
    // busy ignore: second load at accept+5 is dropped
    apply(1'b0, 1'b1, 8'h3C);
    idle(4);
    apply(1'b0, 1'b1, 8'hFF);
    idle(30);
    // back-to-back with load held high
    apply(1'b0, 1'b1, 8'h81);
    repeat (33) apply(1'b0, 1'b1, 8'h7E);
    idle(35);
    // reset mid-frame at accept+10
    apply(1'b0, 1'b1, 8'hF0);
    idle(9);
    apply(1'b1, 1'b0, 8'h00);
    idle(3);
    // load together with reset: reset wins
    apply(1'b1, 1'b1, 8'h55);
    idle(3);
    // LED mirror
    apply(1'b0, 1'b1, 8'hC3);
    idle(35);
    // random traffic: sparse resets, frequent load pulses with random words
    for (int i = 0; i < 1500; i++) begin
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
    end
    idle(36);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
